// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter for the fetch and MEM-stage data ports.
// One transaction is outstanding at a time and data wins over fetch. A completed
// result is held in a done flag until the owning stage advances, so a stalled
// pipeline never reissues an access (in particular, never repeats a store).
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  input  logic          inst_adv,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_stall,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  input  logic          data_adv,
  output logic [DW-1:0] data_rdata,
  output logic          data_stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          bus_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

  state_t        state, state_n;
  logic          inst_done, inst_done_n;
  logic          data_done, data_done_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          bus_req_n, bus_we_n, bus_err_n;
  logic [AW-1:0] bus_addr_n;
  logic [DW-1:0] bus_wdata_n, inst_rdata_n, data_rdata_n;
  logic          inst_cmp, data_cmp;
  logic          timeout;

  // Stall is purely a function of the request and whether its result is held.
  assign inst_stall = inst_req & ~inst_done;
  assign data_stall = data_req & ~data_done;

  // Last cycle of waiting: one more cycle without ack would reach TIMEOUT.
  assign timeout = (tcnt == TW'(TIMEOUT - 1));

  // Next-state, bus command and result capture; everything holds by default.
  always_comb begin
    state_n      = state;
    tcnt_n       = tcnt;
    bus_req_n    = bus_req;
    bus_we_n     = bus_we;
    bus_addr_n   = bus_addr;
    bus_wdata_n  = bus_wdata;
    bus_err_n    = 1'b0;
    inst_rdata_n = inst_rdata;
    data_rdata_n = data_rdata;
    inst_cmp     = 1'b0;
    data_cmp     = 1'b0;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        if (data_req && !data_done) begin
          state_n     = DATA;
          bus_req_n   = 1'b1;
          bus_we_n    = data_we;
          bus_addr_n  = data_addr;
          bus_wdata_n = data_wdata;
        end else if (inst_req && !inst_done) begin
          state_n    = INST;
          bus_req_n  = 1'b1;
          bus_we_n   = 1'b0;
          bus_addr_n = inst_addr;
        end
      end
      INST, DATA: begin
        if (bus_ack) begin
          state_n   = IDLE;
          bus_req_n = 1'b0;
          bus_we_n  = 1'b0;
          if (state == INST) begin
            inst_rdata_n = bus_rdata;
            inst_cmp     = 1'b1;
          end else begin
            if (!bus_we) data_rdata_n = bus_rdata;
            data_cmp = 1'b1;
          end
        end else if (timeout) begin
          // Abort: report the error and release the port with a zero result.
          state_n   = IDLE;
          bus_req_n = 1'b0;
          bus_we_n  = 1'b0;
          bus_err_n = 1'b1;
          if (state == INST) begin
            inst_rdata_n = '0;
            inst_cmp     = 1'b1;
          end else begin
            data_rdata_n = '0;
            data_cmp     = 1'b1;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A completion always sets the flag; otherwise the stage advancing clears it.
    inst_done_n = inst_cmp ? 1'b1 : (inst_adv ? 1'b0 : inst_done);
    data_done_n = data_cmp ? 1'b1 : (data_adv ? 1'b0 : data_done);
  end

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_err    <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      inst_done  <= inst_done_n;
      data_done  <= data_done_n;
      bus_req    <= bus_req_n;
      bus_we     <= bus_we_n;
      bus_err    <= bus_err_n;
      bus_addr   <= bus_addr_n;
      bus_wdata  <= bus_wdata_n;
      inst_rdata <= inst_rdata_n;
      data_rdata <= data_rdata_n;
    end
  end

endmodule
